// File: rtl/router_pkg.sv
// Shared ring-router definitions: header bit positions and one-hot VC buffer states.
package router_pkg;

  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;

  typedef enum logic [2:0] {
    VC_EMPTY = 3'b001,
    VC_FULL  = 3'b010,
    VC_REQ   = 3'b100
  } vc_state_e;

endpackage

// File: rtl/pe_in_vc_buf.sv
// One-deep PE injection buffer for a single virtual channel, with its request/grant FSM.
module pe_in_vc_buf
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter bit          VC_ID      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  grant_cw,
  input  logic                  grant_ccw,
  output logic                  empty,
  output logic                  request_cw,
  output logic                  request_ccw,
  output logic [DATA_WIDTH-1:0] data_out
);

  vc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  away;
  logic                  dir;

  // This VC faces the ring (internal side) whenever the phase is not its own.
  assign away     = polarity ^ VC_ID;
  assign dir      = data_q[DIR_BIT];
  assign empty    = (state_q == VC_EMPTY);
  assign data_out = data_q;

  always_comb begin
    data_d                  = load_data;
    data_d[HOP_MSB:HOP_LSB] = load_data[HOP_MSB:HOP_LSB] >> 1;
  end

  // A held packet presents its request as soon as the phase turns away, so the
  // request is visible the cycle after accept; the REQ/FULL register tracks the phase.
  always_comb begin
    state_d     = state_q;
    request_cw  = 1'b0;
    request_ccw = 1'b0;
    case (state_q)
      VC_EMPTY: begin
        if (load) state_d = VC_FULL;
      end
      VC_FULL, VC_REQ: begin
        if (away) begin
          request_cw  = ~dir;
          request_ccw = dir;
          if ((grant_cw & ~dir) | (grant_ccw & dir)) state_d = VC_EMPTY;
          else                                       state_d = VC_REQ;
        end else begin
          state_d = VC_FULL;
        end
      end
      default: state_d = VC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= VC_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load && (state_q == VC_EMPTY)) data_q <= data_d;
    end
  end

endmodule

// File: rtl/pe_input.sv
// Router PE injection port: accepts PE packets into per-VC buffers and offers them to the ring.
module pe_input
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  pesi,
  output logic                  peri,
  input  logic [DATA_WIDTH-1:0] pedi,
  output logic                  request_cw_even,
  output logic                  request_cw_odd,
  output logic                  request_ccw_even,
  output logic                  request_ccw_odd,
  input  logic                  grant_cw_even,
  input  logic                  grant_cw_odd,
  input  logic                  grant_ccw_even,
  input  logic                  grant_ccw_odd,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd,
  output logic                  vc_err,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  logic empty_even, empty_odd;
  logic offer, good_vc, load_even, load_odd;

  assign peri      = rst & (polarity ? empty_odd : empty_even);
  assign offer     = pesi & peri;
  assign good_vc   = (pedi[VC_BIT] == polarity);
  assign load_even = offer & good_vc & ~polarity;
  assign load_odd  = offer & good_vc & polarity;

  pe_in_vc_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .VC_ID      (1'b0)
  ) u_buf_even (
    .clk         (clk),
    .rst         (rst),
    .polarity    (polarity),
    .load        (load_even),
    .load_data   (pedi),
    .grant_cw    (grant_cw_even),
    .grant_ccw   (grant_ccw_even),
    .empty       (empty_even),
    .request_cw  (request_cw_even),
    .request_ccw (request_ccw_even),
    .data_out    (data_out_even)
  );

  pe_in_vc_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .VC_ID      (1'b1)
  ) u_buf_odd (
    .clk         (clk),
    .rst         (rst),
    .polarity    (polarity),
    .load        (load_odd),
    .load_data   (pedi),
    .grant_cw    (grant_cw_odd),
    .grant_ccw   (grant_ccw_odd),
    .empty       (empty_odd),
    .request_cw  (request_cw_odd),
    .request_ccw (request_ccw_odd),
    .data_out    (data_out_odd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc_err  <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      if (offer && !good_vc) vc_err <= 1'b1;
      if (offer && good_vc)  pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pe_input.sv
// Directed self-checking bench for pe_input.
module tb_pe_input;

  logic        clk = 1'b0;
  logic        rst;
  logic        polarity;
  logic        pesi;
  logic        peri;
  logic [63:0] pedi;
  logic        request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd;
  logic        grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd;
  logic [63:0] data_out_even, data_out_odd;
  logic        vc_err;
  logic [15:0] pkt_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  pe_input #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .polarity         (polarity),
    .pesi             (pesi),
    .peri             (peri),
    .pedi             (pedi),
    .request_cw_even  (request_cw_even),
    .request_cw_odd   (request_cw_odd),
    .request_ccw_even (request_ccw_even),
    .request_ccw_odd  (request_ccw_odd),
    .grant_cw_even    (grant_cw_even),
    .grant_cw_odd     (grant_cw_odd),
    .grant_ccw_even   (grant_ccw_even),
    .grant_ccw_odd    (grant_ccw_odd),
    .data_out_even    (data_out_even),
    .data_out_odd     (data_out_odd),
    .vc_err           (vc_err),
    .pkt_cnt          (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reqs(input string tag, input logic [3:0] exp);
    chk(tag, {60'd0, request_cw_even, request_ccw_even, request_cw_odd, request_ccw_odd}, {60'd0, exp});
  endtask

  initial begin
    rst = 1'b0; polarity = 1'b0; pesi = 1'b0; pedi = '0;
    grant_cw_even = 1'b0; grant_cw_odd = 1'b0; grant_ccw_even = 1'b0; grant_ccw_odd = 1'b0;

    // 1: reset then idle
    repeat (3) @(posedge clk);
    #2;
    chk("rst_peri", peri, 0);
    chk_reqs("rst_reqs", 4'b0000);
    chk("rst_data_even", data_out_even, 0);
    chk("rst_data_odd", data_out_odd, 0);
    chk("rst_vc_err", vc_err, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    rst = 1'b1; #1;
    chk("idle_peri_pol0", peri, 1);
    polarity = 1'b1; #1;
    chk("idle_peri_pol1", peri, 1);
    tick();

    // 2: even cw inject, hop 0xF0 -> 0x78, bits 47:40 untouched
    polarity = 1'b0; pesi = 1'b1; pedi = 64'h00F0_0F00_0000_1234; #1;
    chk("t2_peri", peri, 1);
    tick();
    pesi = 1'b0; polarity = 1'b1; #1;
    chk_reqs("t2_req_cw_even", 4'b1000);
    chk("t2_data_even", data_out_even, 64'h0078_0F00_0000_1234);
    chk("t2_pkt_cnt", pkt_cnt, 1);
    grant_cw_even = 1'b1;
    tick();
    grant_cw_even = 1'b0; #1;
    chk_reqs("t2_req_dropped", 4'b0000);
    chk("t2_data_held", data_out_even, 64'h0078_0F00_0000_1234);
    polarity = 1'b0; #1;
    chk("t2_even_empty", peri, 1);

    // 3: odd ccw inject, hop 0xFF -> 0x7F; request follows polarity until granted
    polarity = 1'b1; pesi = 1'b1; pedi = 64'hC0FF_0000_0000_0001; #1;
    tick();
    pesi = 1'b0; polarity = 1'b0; #1;
    chk_reqs("t3_req_ccw_odd", 4'b0001);
    chk("t3_data_odd", data_out_odd, 64'hC07F_0000_0000_0001);
    chk("t3_pkt_cnt", pkt_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      polarity = ~polarity; #1;
      chk_reqs("t3_req_toggle", polarity ? 4'b0000 : 4'b0001);
      chk("t3_data_hold", data_out_odd, 64'hC07F_0000_0000_0001);
    end
    grant_cw_odd = 1'b1; grant_ccw_even = 1'b1;
    tick();
    grant_cw_odd = 1'b0; grant_ccw_even = 1'b0; #1;
    chk_reqs("t3_wrong_grant_ignored", 4'b0001);
    grant_ccw_odd = 1'b1;
    tick();
    grant_ccw_odd = 1'b0; #1;
    chk_reqs("t3_granted", 4'b0000);
    polarity = 1'b1; #1;
    chk("t3_odd_empty", peri, 1);

    // 4: backpressure on even buffer
    polarity = 1'b0; pesi = 1'b1; pedi = 64'h0002_0000_0000_00AA;
    tick();
    pedi = 64'h0010_0000_0000_00BB; #1;
    chk("t4_pkt_cnt", pkt_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_peri_low", peri, 0);
      tick();
      chk("t4_cnt_hold", pkt_cnt, 3);
      chk("t4_data_hold", data_out_even, 64'h0001_0000_0000_00AA);
    end
    chk_reqs("t4_no_req_own_phase", 4'b0000);
    pesi = 1'b0; polarity = 1'b1; #1;
    chk_reqs("t4_req", 4'b1000);
    grant_cw_even = 1'b1;
    tick();
    grant_cw_even = 1'b0; polarity = 1'b0; pesi = 1'b1; #1;
    chk("t4_peri_after_drain", peri, 1);
    tick();
    pesi = 1'b0; #1;
    chk("t4_pkt_cnt2", pkt_cnt, 4);
    chk("t4_data2", data_out_even, 64'h0008_0000_0000_00BB);
    polarity = 1'b1; grant_cw_even = 1'b1;
    tick();
    grant_cw_even = 1'b0;

    // 5: wrong VC
    polarity = 1'b0; pesi = 1'b1; pedi = 64'h8000_0000_0000_0055; #1;
    chk("t5_peri", peri, 1);
    tick();
    pesi = 1'b0; #1;
    chk("t5_vc_err", vc_err, 1);
    chk("t5_pkt_cnt", pkt_cnt, 4);
    polarity = 1'b1; #1;
    chk_reqs("t5_not_loaded", 4'b0000);
    chk("t5_odd_empty", peri, 1);
    pesi = 1'b1; pedi = 64'h8004_0000_0000_0066;
    tick();
    pesi = 1'b0; polarity = 1'b0; #1;
    chk_reqs("t5_valid_after_err", 4'b0010);
    chk("t5_data_odd", data_out_odd, 64'h8002_0000_0000_0066);
    chk("t5_pkt_cnt2", pkt_cnt, 5);
    chk("t5_vc_err_sticky", vc_err, 1);

    // 6: reset mid-request with both VCs occupied
    pesi = 1'b1; pedi = 64'h4000_0000_0000_0077;
    tick();
    pesi = 1'b0; polarity = 1'b1; #1;
    chk_reqs("t6_req_ccw_even", 4'b0100);
    rst = 1'b0; #1;
    chk_reqs("t6_reqs_in_reset", 4'b0000);
    chk("t6_peri_in_reset", peri, 0);
    chk("t6_pkt_cnt", pkt_cnt, 0);
    chk("t6_vc_err", vc_err, 0);
    chk("t6_data_even", data_out_even, 0);
    tick();
    rst = 1'b1; #1;
    chk("t6_peri_pol1", peri, 1);
    chk_reqs("t6_reqs_after", 4'b0000);
    polarity = 1'b0; #1;
    chk("t6_peri_pol0", peri, 1);
    tick();
    polarity = 1'b1; #1;
    chk_reqs("t6_no_glitch", 4'b0000);
    chk("t6_odd_empty", peri, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
